// File: rtl/mac_pkg.sv
// Shared definitions for the MAC sequencer: state encoding and default sizes.
package mac_pkg;

  localparam int unsigned MAC_W       = 8;
  localparam int unsigned MAC_LEN_W   = 4;
  localparam int unsigned MAC_TIMEOUT = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    ISSUE  = 3'd2,
    WAIT   = 3'd3,
    RESULT = 3'd4
  } mac_state_e;

endpackage

// File: rtl/mac_seq_wdog.sv
// Watchdog for the WAIT state: flags expiry on the TIMEOUT-th consecutive enabled cycle.
module mac_seq_wdog
  import mac_pkg::*;
#(
  parameter int unsigned TIMEOUT = MAC_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d   = en ? cnt_q + 1'b1 : '0;
    expired = en && (cnt_q == CW'(TIMEOUT - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer for the 8-bit MAC: fetches Len operand pairs, issues them, returns the sum.
// Optional WAIT watchdog with sticky Err is built when MAC_SEQ_TIMEOUT_EN is defined.
module mac_seq_ctrl
  import mac_pkg::*;
#(
  parameter int unsigned W       = MAC_W,
  parameter int unsigned LEN_W   = MAC_LEN_W
`ifdef MAC_SEQ_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT = MAC_TIMEOUT
`endif
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [LEN_W-1:0] Len,
  input  logic [W-1:0]     Acc_init,
  output logic             Busy,
  input  logic             Op_valid,
  output logic             Op_ready,
  input  logic [W-1:0]     Op_b,
  input  logic [W-1:0]     Op_c,
  output logic             Mac_load,
  output logic [W-1:0]     Mac_ain,
  output logic [W-1:0]     Mac_b,
  output logic [W-1:0]     Mac_c,
  input  logic             Mac_done,
  input  logic [W-1:0]     Mac_aout,
  output logic             Res_valid,
  input  logic             Res_ready,
  output logic [W-1:0]     Result,
  output logic             Err
);

  mac_state_e       state_q, state_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     c_q, c_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_inc;
  logic             wd_expired;

`ifdef MAC_SEQ_TIMEOUT_EN
  logic err_q, err_d;

  mac_seq_wdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk    (Clk),
    .rst_n  (Reset),
    .en     (state_q == WAIT),
    .expired(wd_expired)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign Err = err_q;
`else
  assign wd_expired = 1'b0;
  assign Err        = 1'b0;
`endif

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    b_d     = b_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
`ifdef MAC_SEQ_TIMEOUT_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          len_d   = Len;
          acc_d   = Acc_init;
          cnt_d   = '0;
`ifdef MAC_SEQ_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = (Len == '0) ? RESULT : FETCH;
        end
      end
      FETCH: begin
        if (Op_valid) begin
          b_d     = Op_b;
          c_d     = Op_c;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        // A Done in the expiry cycle still wins, so a just-in-time result is kept.
        if (Mac_done) begin
          acc_d   = Mac_aout;
          cnt_d   = cnt_inc;
          state_d = (cnt_inc == len_q) ? RESULT : FETCH;
        end else if (wd_expired) begin
`ifdef MAC_SEQ_TIMEOUT_EN
          err_d   = 1'b1;
`endif
          state_d = RESULT;
        end
      end
      RESULT: begin
        if (Res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      b_q     <= '0;
      c_q     <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  assign Busy      = (state_q != IDLE);
  assign Op_ready  = (state_q == FETCH);
  assign Mac_load  = (state_q == ISSUE);
  assign Res_valid = (state_q == RESULT);
  assign Mac_ain   = acc_q;
  assign Mac_b     = b_q;
  assign Mac_c     = c_q;
  assign Result    = acc_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed, scoreboarded bench for mac_seq_ctrl with a behavioural MAC of programmable latency.
module tb_mac_seq_ctrl;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       Start = 1'b0;
  logic [3:0] Len = '0;
  logic [7:0] Acc_init = '0;
  logic       Busy;
  logic       Op_valid = 1'b0;
  logic       Op_ready;
  logic [7:0] Op_b = '0;
  logic [7:0] Op_c = '0;
  logic       Mac_load;
  logic [7:0] Mac_ain, Mac_b, Mac_c;
  logic       Mac_done = 1'b0;
  logic [7:0] Mac_aout = '0;
  logic       Res_valid;
  logic       Res_ready = 1'b0;
  logic [7:0] Result;
  logic       Err;

  mac_seq_ctrl #(.W(8), .LEN_W(4)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Len(Len), .Acc_init(Acc_init),
    .Busy(Busy), .Op_valid(Op_valid), .Op_ready(Op_ready), .Op_b(Op_b), .Op_c(Op_c),
    .Mac_load(Mac_load), .Mac_ain(Mac_ain), .Mac_b(Mac_b), .Mac_c(Mac_c),
    .Mac_done(Mac_done), .Mac_aout(Mac_aout), .Res_valid(Res_valid),
    .Res_ready(Res_ready), .Result(Result), .Err(Err)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [7:0] ain;
    logic [7:0] b;
    logic [7:0] c;
  } iss_t;

  iss_t       iq[$];
  logic [7:0] rq[$];
  logic [7:0] pb[16];
  logic [7:0] pc[16];
  int         checks = 0;
  int         errors = 0;
  int         load_cnt = 0;
  int         mac_lat = 1;
  int         mac_pend = 0;
  logic [7:0] m_ain, m_b, m_c;
  iss_t       mon_e;
  iss_t       held;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clk);
  endtask

  // Behavioural MAC: Done pulses mac_lat cycles after Load; mac_lat=0 never answers.
  always @(posedge Clk) begin
    #1;
    Mac_done = 1'b0;
    if (mac_pend > 0) begin
      mac_pend--;
      if (mac_pend == 0) begin
        Mac_done = 1'b1;
        Mac_aout = m_ain + m_b * m_c;
      end
    end
    if (Reset && Mac_load) begin
      mac_pend = mac_lat;
      m_ain = Mac_ain;
      m_b   = Mac_b;
      m_c   = Mac_c;
    end
  end

  // Issue monitor: checks each Load against the scoreboard and operand stability in WAIT.
  always @(posedge Clk) begin
    #1;
    if (Reset && Mac_load) begin
      load_cnt++;
      if (iq.size() == 0) chk("stray_load", Mac_load, 0);
      else begin
        mon_e = iq.pop_front();
        chk("issue_ain", Mac_ain, mon_e.ain);
        chk("issue_b", Mac_b, mon_e.b);
        chk("issue_c", Mac_c, mon_e.c);
        held = mon_e;
      end
    end else if (Reset && Busy && !Op_ready && !Res_valid) begin
      chk("wait_ain", Mac_ain, held.ain);
      chk("wait_b", Mac_b, held.b);
      chk("wait_c", Mac_c, held.c);
    end
  end

  task automatic run_job(input int len, input logic [7:0] init, input int gap,
                         input int rdelay, input int lat, input bit poke);
    logic [7:0] a;
    int base;
    int t;
    mac_lat = lat;
    a = init;
    for (int i = 0; i < len; i++) begin
      iq.push_back('{a, pb[i], pc[i]});
      a = a + pb[i] * pc[i];
    end
    rq.push_back(a);
    base = load_cnt;
    chk("pre_idle", Busy, 0);
    Len = len[3:0];
    Acc_init = init;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    if (len == 0) begin
      chk("zl_res_valid", Res_valid, 1);
      chk("zl_op_ready", Op_ready, 0);
      chk("zl_result", Result, init);
    end else begin
      chk("busy_after_start", Busy, 1);
    end
    for (int i = 0; i < len; i++) begin
      Start = poke;
      Acc_init = poke ? 8'hAA : init;
      repeat (gap) tick();
      Op_valid = 1'b1;
      Op_b = pb[i];
      Op_c = pc[i];
      t = 0;
      while (!Op_ready && t < 200) begin
        tick();
        t++;
      end
      chk("op_ready_wait", Op_ready, 1);
      tick();
      Op_valid = 1'b0;
      Start = 1'b0;
    end
    t = 0;
    while (!Res_valid && t < 200) begin
      tick();
      t++;
    end
    chk("res_valid_wait", Res_valid, 1);
    Start = poke;
    repeat (rdelay) begin
      tick();
      chk("res_hold_valid", Res_valid, 1);
      chk("res_hold_value", Result, rq[0]);
    end
    Start = 1'b0;
    Acc_init = init;
    Res_ready = 1'b1;
    chk("result", Result, rq[0]);
    chk("load_count", load_cnt - base, len);
    void'(rq.pop_front());
    tick();
    Res_ready = 1'b0;
    chk("res_drop", Res_valid, 0);
    chk("idle_after", Busy, 0);
    chk("err_clear", Err, 0);
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_busy", Busy, 0);
    chk("rst_op_ready", Op_ready, 0);
    chk("rst_load", Mac_load, 0);
    chk("rst_res_valid", Res_valid, 0);
    chk("rst_result", Result, 0);
    chk("rst_ain", Mac_ain, 0);
    chk("rst_err", Err, 0);
    Reset = 1'b1;
    tick();

    pb[0] = 8'd2; pc[0] = 8'd3;
    pb[1] = 8'd4; pc[1] = 8'd5;
    pb[2] = 8'd1; pc[2] = 8'd1;
    run_job(3, 8'h00, 0, 2, 2, 1'b0);

    pb[0] = 8'h10; pc[0] = 8'h02;
    run_job(1, 8'hF0, 0, 0, 1, 1'b0);

    run_job(0, 8'h5A, 0, 1, 1, 1'b0);

    pb[0] = 8'h03; pc[0] = 8'h07;
    pb[1] = 8'hFF; pc[1] = 8'hFF;
    pb[2] = 8'h09; pc[2] = 8'h09;
    pb[3] = 8'h01; pc[3] = 8'h00;
    run_job(4, 8'h01, 4, 5, 3, 1'b1);

    // Back-to-back job using 15 pairs at 1-cycle latency.
    for (int i = 0; i < 15; i++) begin
      pb[i] = 8'(i * 17 + 3);
      pc[i] = 8'(i + 5);
    end
    run_job(15, 8'h33, 0, 0, 1, 1'b0);

    // Reset in WAIT, then a late Done that must be ignored.
    pb[0] = 8'h05; pc[0] = 8'h06;
    pb[1] = 8'h07; pc[1] = 8'h08;
    mac_lat = 4;
    iq.push_back('{8'h44, 8'h05, 8'h06});
    Len = 4'd2;
    Acc_init = 8'h44;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    Op_valid = 1'b1;
    Op_b = 8'h05;
    Op_c = 8'h06;
    chk("rw_op_ready", Op_ready, 1);
    tick();
    Op_valid = 1'b0;
    chk("rw_load", Mac_load, 1);
    tick();
    chk("rw_in_wait", Busy, 1);
    Reset = 1'b0;
    #1;
    chk("rw_busy", Busy, 0);
    chk("rw_load0", Mac_load, 0);
    chk("rw_ain", Mac_ain, 0);
    chk("rw_b", Mac_b, 0);
    chk("rw_c", Mac_c, 0);
    chk("rw_result", Result, 0);
    chk("rw_res_valid", Res_valid, 0);
    tick();
    Reset = 1'b1;
    iq.delete();
    repeat (6) begin
      tick();
      chk("late_busy", Busy, 0);
      chk("late_result", Result, 0);
      chk("late_op_ready", Op_ready, 0);
    end

`ifdef MAC_SEQ_TIMEOUT_EN
    // Second pair never completes: watchdog expires after 16 WAIT cycles.
    mac_lat = 1;
    iq.push_back('{8'h11, 8'h01, 8'h02});
    iq.push_back('{8'h13, 8'h03, 8'h03});
    Len = 4'd2;
    Acc_init = 8'h11;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    Op_valid = 1'b1;
    Op_b = 8'h01;
    Op_c = 8'h02;
    tick();
    Op_valid = 1'b0;
    repeat (3) tick();
    chk("to_fetch2", Op_ready, 1);
    mac_lat = 0;
    Op_valid = 1'b1;
    Op_b = 8'h03;
    Op_c = 8'h03;
    tick();
    Op_valid = 1'b0;
    chk("to_issue", Mac_load, 1);
    repeat (16) begin
      tick();
      chk("to_waiting", Res_valid, 0);
      chk("to_err_low", Err, 0);
    end
    tick();
    chk("to_res_valid", Res_valid, 1);
    chk("to_err", Err, 1);
    chk("to_result", Result, 8'h13);
    Res_ready = 1'b1;
    tick();
    Res_ready = 1'b0;
    chk("to_err_sticky", Err, 1);
    chk("to_idle", Busy, 0);
    Len = 4'd0;
    Acc_init = 8'h22;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("to_err_cleared", Err, 0);
    chk("to_zl_result", Result, 8'h22);
    Res_ready = 1'b1;
    tick();
    Res_ready = 1'b0;
    mac_lat = 1;
`endif

    chk("final_idle", Busy, 0);
    chk("sb_issue_empty", iq.size(), 0);
    chk("sb_result_empty", rq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
